mips_instr_encoder: RTL and testbench

//  Encodes symbolic instruction requests (format + fields, or pseudo-op) into 32-bit MIPS words and writes them

---
 rtl/mips_instr_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_instr_encoder
// Description : Turns symbolic instruction requests (R/I/J formats and the
//               NOP/MOVE/LI/BLT/BGE pseudo-ops) into 32-bit MIPS words and
//               writes them sequentially into instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [4:0]        AT_REG    = 5'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [5:0]        req_opc,
   input  logic [5:0]        req_funct,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_sa,
   input  logic [31:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              err,
   output logic              wrapped
);

   // FSM states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EMIT1 = 2'd1;
   localparam logic [1:0] S_EMIT2 = 2'd2;

   // Request operation codes
   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_I    = 4'd1;
   localparam logic [3:0] OP_J    = 4'd2;
   localparam logic [3:0] OP_NOP  = 4'd3;
   localparam logic [3:0] OP_MOVE = 4'd4;
   localparam logic [3:0] OP_LI   = 4'd5;
   localparam logic [3:0] OP_BLT  = 4'd6;
   localparam logic [3:0] OP_BGE  = 4'd7;

   // MIPS opcode / funct values used by the pseudo-op expansions
   localparam logic [5:0] MIPS_SPECIAL = 6'b000000;
   localparam logic [5:0] MIPS_ORI     = 6'b001101;
   localparam logic [5:0] MIPS_LUI     = 6'b001111;
   localparam logic [5:0] MIPS_BEQ     = 6'b000100;
   localparam logic [5:0] MIPS_BNE     = 6'b000101;
   localparam logic [5:0] FN_ADDU      = 6'b100001;
   localparam logic [5:0] FN_SLT       = 6'b101010;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [31:0]       second_q;
   logic              two_q;
   logic              err_q;
   logic              wrapped_q;

   logic [31:0]       w_first;
   logic [31:0]       w_second;
   logic              w_two;
   logic              w_supported;
   logic [15:0]       w_imm_hi;
   logic [15:0]       w_imm_lo;
   logic [15:0]       w_br_off;
   logic [31:0]       w_slt;
   logic              w_accept;
   logic              w_wr_done;

   assign w_accept  = req_valid & req_ready;
   assign w_wr_done = wr_en & wr_ready;

   // Encode the presented request into up to two instruction words
   always_comb begin
      w_first     = '0;
      w_second    = '0;
      w_two       = 1'b0;
      w_supported = 1'b1;
      w_imm_hi    = req_imm[31:16];
      w_imm_lo    = req_imm[15:0];
      // Branch offsets are relative to the SLT word, the branch sits one later
      w_br_off    = w_imm_lo - 16'd1;
      w_slt       = {MIPS_SPECIAL, req_rs, req_rt, AT_REG, 5'd0, FN_SLT};
      case (req_op)
         OP_R:    w_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, req_sa, req_funct};
         OP_I:    w_first = {req_opc, req_rs, req_rt, w_imm_lo};
         OP_J:    w_first = {req_opc, req_target};
         OP_NOP:  w_first = 32'h0000_0000;
         OP_MOVE: w_first = {MIPS_SPECIAL, req_rs, 5'd0, req_rd, 5'd0, FN_ADDU};
         OP_LI: begin
            if (w_imm_hi == 16'd0) begin
               w_first = {MIPS_ORI, 5'd0, req_rt, w_imm_lo};
            end else if (w_imm_lo == 16'd0) begin
               w_first = {MIPS_LUI, 5'd0, req_rt, w_imm_hi};
            end else begin
               w_first  = {MIPS_LUI, 5'd0, req_rt, w_imm_hi};
               w_second = {MIPS_ORI, req_rt, req_rt, w_imm_lo};
               w_two    = 1'b1;
            end
         end
         OP_BLT: begin
            w_first  = w_slt;
            w_second = {MIPS_BNE, AT_REG, 5'd0, w_br_off};
            w_two    = 1'b1;
         end
         OP_BGE: begin
            w_first  = w_slt;
            w_second = {MIPS_BEQ, AT_REG, 5'd0, w_br_off};
            w_two    = 1'b1;
         end
         default: w_supported = 1'b0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: advance only on a completed write handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept && w_supported) begin
               state_d = S_EMIT1;
            end
         end
         S_EMIT1: begin
            if (wr_ready) begin
               state_d = two_q ? S_EMIT2 : S_IDLE;
            end
         end
         S_EMIT2: begin
            if (wr_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: start steals the idle cycle from any pending request
   always_comb begin
      wr_en     = (state_q == S_EMIT1) || (state_q == S_EMIT2);
      req_ready = (state_q == S_IDLE) && !start;
   end

   // Address, data and sticky status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= BASE_ADDR;
         data_q    <= '0;
         second_q  <= '0;
         two_q     <= 1'b0;
         err_q     <= 1'b0;
         wrapped_q <= 1'b0;
      end else if ((state_q == S_IDLE) && start) begin
         addr_q    <= BASE_ADDR;
         err_q     <= 1'b0;
         wrapped_q <= 1'b0;
      end else if (w_accept) begin
         if (w_supported) begin
            data_q   <= w_first;
            second_q <= w_second;
            two_q    <= w_two;
         end else begin
            err_q    <= 1'b1;
         end
      end else if (w_wr_done) begin
         addr_q <= addr_q + ADDR_ONE;
         if (&addr_q) begin
            wrapped_q <= 1'b1;
         end
         if ((state_q == S_EMIT1) && two_q) begin
            data_q <= second_q;
         end
      end
   end

   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign err     = err_q;
   assign wrapped = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_instr_encoder
// Description : Directed self-checking bench for mips_instr_encoder with a
//               write scoreboard; a second narrow-address instance covers
//               address wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [5:0]  req_opc;
   logic [5:0]  req_funct;
   logic [4:0]  req_rs, req_rt, req_rd, req_sa;
   logic [31:0] req_imm;
   logic [25:0] req_target;
   logic        wr_ready;

   logic        req_ready, wr_en, err, wrapped;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;

   logic        req_ready_w, wr_en_w, err_w, wrapped_w;
   logic [1:0]  wr_addr_w;
   logic [31:0] wr_data_w;

   int          checks = 0;
   int          errors = 0;
   logic [39:0] sb[$];
   logic [7:0]  exp_addr;

   always #5 clk = ~clk;

   mips_instr_encoder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_opc(req_opc), .req_funct(req_funct), .req_rs(req_rs),
      .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa), .req_imm(req_imm),
      .req_target(req_target), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .err(err), .wrapped(wrapped)
   );

   mips_instr_encoder #(.ADDR_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready_w),
      .req_op(req_op), .req_opc(req_opc), .req_funct(req_funct), .req_rs(req_rs),
      .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa), .req_imm(req_imm),
      .req_target(req_target), .wr_en(wr_en_w), .wr_ready(wr_ready), .wr_addr(wr_addr_w),
      .wr_data(wr_data_w), .err(err_w), .wrapped(wrapped_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] data);
      sb.push_back({exp_addr, data});
      exp_addr = exp_addr + 8'd1;
   endtask

   // Present one request for exactly one cycle; called #1 after a rising edge
   task automatic issue(input logic [3:0] op, input logic [5:0] opc, input logic [5:0] funct,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sa, input logic [31:0] imm, input logic [25:0] tgt);
      req_op = op; req_opc = opc; req_funct = funct; req_rs = rs; req_rt = rt;
      req_rd = rd; req_sa = sa; req_imm = imm; req_target = tgt;
      req_valid = 1'b1;
      #1;
      chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         if (req_ready === 1'b1 && wr_en === 1'b0) break;
         @(posedge clk); #1;
      end
      chk("idle_reached", {31'd0, req_ready}, 32'd1);
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   // Scoreboard: every completed write must match the oldest expected word
   always @(negedge clk) begin
      logic [39:0] e;
      if (rst_n === 1'b1 && wr_en === 1'b1 && wr_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[39:32]});
            chk("wr_data", wr_data, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hold_addr;
      rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
      req_op = '0; req_opc = '0; req_funct = '0; req_rs = '0; req_rt = '0;
      req_rd = '0; req_sa = '0; req_imm = '0; req_target = '0;
      exp_addr = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_wrapped", {31'd0, wrapped}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;

      // MOVE $3 <- $5, with latency checks
      push_word(32'h00A01821);
      issue(4'd4, 6'd0, 6'd0, 5'd5, 5'd0, 5'd3, 5'd0, 32'd0, 26'd0);
      chk("move_wr_en", {31'd0, wr_en}, 32'd1);
      chk("move_data_next_cycle", wr_data, 32'h00A01821);
      chk("move_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("move_ready_again", {31'd0, req_ready}, 32'd1);
      chk("move_addr_incr", {24'd0, wr_addr}, 32'd1);
      wait_idle();

      // LI variants
      push_word(32'h3C081234); push_word(32'h35085678);
      issue(4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0);
      wait_idle();
      push_word(32'h3408ABCD);
      issue(4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000ABCD, 26'd0);
      wait_idle();
      push_word(32'h3C08ABCD);
      issue(4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'hABCD0000, 26'd0);
      wait_idle();

      // BLT / BGE including offset wrap boundaries
      push_word(32'h0085082A); push_word(32'h1420000F);
      issue(4'd6, 6'd0, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 32'h00000010, 26'd0);
      wait_idle();
      push_word(32'h0085082A); push_word(32'h1020000F);
      issue(4'd7, 6'd0, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 32'h00000010, 26'd0);
      wait_idle();
      push_word(32'h0085082A); push_word(32'h1420FFFF);
      issue(4'd6, 6'd0, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 32'h00000000, 26'd0);
      wait_idle();
      push_word(32'h0085082A); push_word(32'h10207FFF);
      issue(4'd7, 6'd0, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 32'h00008000, 26'd0);
      wait_idle();

      // Plain formats and NOP
      push_word(32'h00221920);
      issue(4'd0, 6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFFFFFF, 26'h3FFFFFF);
      wait_idle();
      push_word(32'h8FA8FFFC);
      issue(4'd1, 6'h23, 6'h3F, 5'd29, 5'd8, 5'd31, 5'd31, 32'h1234FFFC, 26'h3FFFFFF);
      wait_idle();
      push_word(32'h08123456);
      issue(4'd2, 6'h02, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 26'h0123456);
      wait_idle();
      push_word(32'h00000000);
      issue(4'd3, 6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 26'h3FFFFFF);
      wait_idle();

      // Back-pressure: 3 stalled cycles, write lands on the 4th
      hold_addr = exp_addr;
      push_word(32'h8FA8FFFC);
      wr_ready = 1'b0;
      issue(4'd1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 32'h0000FFFC, 26'd0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_wr_en", {31'd0, wr_en}, 32'd1);
         chk("stall_addr", {24'd0, wr_addr}, {24'd0, hold_addr});
         chk("stall_data", wr_data, 32'h8FA8FFFC);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      wr_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_done", {31'd0, wr_en}, 32'd0);
      wait_idle();

      // Unsupported op: accepted, no write, sticky err
      issue(4'hF, 6'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd1, 32'd1, 26'd1);
      chk("unsup_no_write", {31'd0, wr_en}, 32'd0);
      chk("unsup_err", {31'd1 & 31'd0, err}, 32'd1);
      chk("unsup_ready", {31'd0, req_ready}, 32'd1);
      chk("unsup_addr_kept", {24'd0, wr_addr}, {24'd0, exp_addr});
      @(posedge clk); #1;
      chk("err_sticky", {31'd0, err}, 32'd1);

      // start wins over a simultaneous request
      start = 1'b1;
      req_op = 4'd4; req_valid = 1'b1;
      #1;
      chk("start_blocks_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; req_valid = 1'b0;
      #1;
      chk("start_err_clear", {31'd0, err}, 32'd0);
      chk("start_addr_base", {24'd0, wr_addr}, 32'd0);
      chk("start_no_accept", {31'd0, wr_en}, 32'd0);
      exp_addr = 8'd0;
      @(posedge clk); #1;

      // Reset in the middle of a two-word expansion discards everything
      wr_ready = 1'b0;
      issue(4'd5, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0);
      chk("midop_wr_en", {31'd0, wr_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("async_rst_data", wr_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", {31'd0, wr_en}, 32'd0);
      chk("post_rst_addr", {24'd0, wr_addr}, 32'd0);

      // Address wrap on the 2-bit instance
      exp_addr = 8'd0;
      for (int i = 0; i < 5; i++) begin
         push_word(32'h00000000);
         issue(4'd3, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
         chk("wrap_addr", {30'd0, wr_addr_w}, i % 4);
         wait_idle();
         if (i == 2) chk("wrap_not_yet", {31'd0, wrapped_w}, 32'd0);
      end
      chk("wrap_set", {31'd0, wrapped_w}, 32'd1);
      chk("wide_not_wrapped", {31'd0, wrapped}, 32'd0);
      chk("wrap_addr_after", {30'd0, wr_addr_w}, 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_wrap_clear", {31'd0, wrapped_w}, 32'd0);
      chk("start_wrap_addr", {30'd0, wr_addr_w}, 32'd0);
      chk("start_wide_addr", {24'd0, wr_addr}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
